rs_unit: RTL and testbench

Reservation station that sits directly downstream of the issue stage. It holds up to DEPTH issued instructions for one functional-unit class (add/sub or mul/div), together with operand values or ROB tags. It snoops the common data bus (CDB) for pending operands and dispatches the oldest ready instruction to its functional unit through a valid/ready handshake. It replaces the ad-hoc per-class occupancy counters with an exported occupancy count.

---
 rtl/tomasulo_pkg.sv | 25 ++
 rtl/rs_select.sv | 23 ++
 rtl/rs_unit.sv | 171 +++++++++++++++++
 tb/tb_rs_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, opcodes and the reservation-station entry.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned FUNC_W = 4;

    localparam logic [FUNC_W-1:0] ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] DIV = 4'b0011;

    typedef struct packed {
        logic              valid;
        logic [FUNC_W-1:0] func;
        logic [TAG_W-1:0]  rob;
        logic              busy_a;
        logic [TAG_W-1:0]  tag_a;
        logic [DATA_W-1:0] val_a;
        logic              busy_b;
        logic [TAG_W-1:0]  tag_b;
        logic [DATA_W-1:0] val_b;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: returns the lowest set index of a ready vector.
module rs_select #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] ready,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan from youngest to oldest so the oldest ready entry wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_unit.sv
// Reservation station: age-ordered shifting queue with CDB snoop and oldest-ready dispatch.
module rs_unit #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = tomasulo_pkg::DATA_W,
    parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W,
    parameter int unsigned FUNC_W = tomasulo_pkg::FUNC_W,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [FUNC_W-1:0] iss_func,
    input  logic [TAG_W-1:0]  iss_rob,
    input  logic              iss_rs1_busy,
    input  logic [TAG_W-1:0]  iss_rs1_tag,
    input  logic [DATA_W-1:0] iss_rs1_val,
    input  logic              iss_rs2_busy,
    input  logic [TAG_W-1:0]  iss_rs2_tag,
    input  logic [DATA_W-1:0] iss_rs2_val,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [FUNC_W-1:0] disp_func,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic [TAG_W-1:0]  disp_rob,
    output logic [CNT_W-1:0]  count
);

    import tomasulo_pkg::*;

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t entries_q [DEPTH];
    rs_entry_t entries_d [DEPTH];
    rs_entry_t snoop     [DEPTH];
    rs_entry_t new_entry;
    rs_entry_t sel_entry;

    logic [CNT_W-1:0] count_q, count_d, tail;
    logic [DEPTH-1:0] ready;
    logic             sel_hit;
    logic [IDX_W-1:0] sel_idx;
    logic             do_iss, do_disp;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = entries_q[i].valid && !entries_q[i].busy_a && !entries_q[i].busy_b;
        end
    end

    rs_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (ready),
        .hit   (sel_hit),
        .idx   (sel_idx)
    );

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(sel_idx)) begin
                sel_entry = entries_q[i];
            end
        end
    end

    assign iss_ready  = (count_q != CNT_W'(DEPTH));
    assign disp_valid = sel_hit && !flush;
    assign disp_func  = disp_valid ? sel_entry.func  : '0;
    assign disp_a     = disp_valid ? sel_entry.val_a : '0;
    assign disp_b     = disp_valid ? sel_entry.val_b : '0;
    assign disp_rob   = disp_valid ? sel_entry.rob   : '0;
    assign count      = count_q;

    assign do_disp = disp_valid && disp_ready;
    assign do_iss  = iss_valid && iss_ready && !flush;
    assign tail    = count_q - CNT_W'(do_disp);

    // Operand capture at issue, with a same-cycle bypass from the CDB.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.func  = iss_func;
        new_entry.rob   = iss_rob;
        if (!iss_rs1_busy) begin
            new_entry.val_a = iss_rs1_val;
        end else if (cdb_valid && cdb_tag == iss_rs1_tag) begin
            new_entry.val_a = cdb_data;
        end else begin
            new_entry.busy_a = 1'b1;
            new_entry.tag_a  = iss_rs1_tag;
        end
        if (!iss_rs2_busy) begin
            new_entry.val_b = iss_rs2_val;
        end else if (cdb_valid && cdb_tag == iss_rs2_tag) begin
            new_entry.val_b = cdb_data;
        end else begin
            new_entry.busy_b = 1'b1;
            new_entry.tag_b  = iss_rs2_tag;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop[i] = entries_q[i];
            if (cdb_valid && entries_q[i].valid) begin
                if (entries_q[i].busy_a && entries_q[i].tag_a == cdb_tag) begin
                    snoop[i].busy_a = 1'b0;
                    snoop[i].val_a  = cdb_data;
                end
                if (entries_q[i].busy_b && entries_q[i].tag_b == cdb_tag) begin
                    snoop[i].busy_b = 1'b0;
                    snoop[i].val_b  = cdb_data;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = snoop[i];
        end

        // Remove the dispatched entry and close the gap behind it.
        if (do_disp) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    entries_d[i] = snoop[i + 1];
                end
            end
            entries_d[DEPTH-1] = '0;
        end

        if (do_iss) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(tail)) begin
                    entries_d[i] = new_entry;
                end
            end
        end

        count_d = count_q + CNT_W'(do_iss) - CNT_W'(do_disp);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rs_unit.sv
// Directed self-checking bench for rs_unit; checks sampled on the falling clock edge.
module tb_rs_unit;

    import tomasulo_pkg::*;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              iss_valid;
    logic              iss_ready;
    logic [FUNC_W-1:0] iss_func;
    logic [TAG_W-1:0]  iss_rob;
    logic              iss_rs1_busy;
    logic [TAG_W-1:0]  iss_rs1_tag;
    logic [DATA_W-1:0] iss_rs1_val;
    logic              iss_rs2_busy;
    logic [TAG_W-1:0]  iss_rs2_tag;
    logic [DATA_W-1:0] iss_rs2_val;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [FUNC_W-1:0] disp_func;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [TAG_W-1:0]  disp_rob;
    logic [1:0]        count;

    int n_cmp  = 0;
    int n_fail = 0;

    rs_unit dut (
        .clk1         (clk1),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_func     (iss_func),
        .iss_rob      (iss_rob),
        .iss_rs1_busy (iss_rs1_busy),
        .iss_rs1_tag  (iss_rs1_tag),
        .iss_rs1_val  (iss_rs1_val),
        .iss_rs2_busy (iss_rs2_busy),
        .iss_rs2_tag  (iss_rs2_tag),
        .iss_rs2_val  (iss_rs2_val),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_func    (disp_func),
        .disp_a       (disp_a),
        .disp_b       (disp_b),
        .disp_rob     (disp_rob),
        .count        (count)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic issue(input logic [3:0] f, input logic [2:0] rob,
                         input logic b1, input logic [2:0] t1, input logic [15:0] v1,
                         input logic b2, input logic [2:0] t2, input logic [15:0] v2);
        iss_valid    = 1'b1;
        iss_func     = f;
        iss_rob      = rob;
        iss_rs1_busy = b1;
        iss_rs1_tag  = t1;
        iss_rs1_val  = v1;
        iss_rs2_busy = b2;
        iss_rs2_tag  = t2;
        iss_rs2_val  = v2;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic quiet();
        iss_valid  = 1'b0;
        cdb_valid  = 1'b0;
        disp_ready = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue(ADD, 3'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
        quiet();
        cdb_tag  = '0;
        cdb_data = '0;
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_a", 32'(disp_a), 32'd0);
        rst = 1'b0;
        step();

        // Ready issue and dispatch.
        issue(ADD, 3'd2, 1'b0, 3'd0, 16'd5, 1'b0, 3'd0, 16'd7);
        step();
        quiet();
        chk("rdy_valid", 32'(disp_valid), 32'd1);
        chk("rdy_a", 32'(disp_a), 32'd5);
        chk("rdy_b", 32'(disp_b), 32'd7);
        chk("rdy_rob", 32'(disp_rob), 32'd2);
        chk("rdy_count", 32'(count), 32'd1);
        disp_ready = 1'b1;
        step();
        quiet();
        chk("rdy_count_after", 32'(count), 32'd0);
        chk("rdy_valid_after", 32'(disp_valid), 32'd0);

        // CDB wakeup.
        issue(MUL, 3'd1, 1'b1, 3'd4, 16'd0, 1'b0, 3'd0, 16'd3);
        step();
        quiet();
        chk("wake_blocked", 32'(disp_valid), 32'd0);
        chk("wake_disp_a_zero", 32'(disp_a), 32'd0);
        step();
        chk("wake_blocked2", 32'(disp_valid), 32'd0);
        cdb(3'd4, 16'h00AA);
        step();
        quiet();
        chk("wake_valid", 32'(disp_valid), 32'd1);
        chk("wake_a", 32'(disp_a), 32'h00AA);
        chk("wake_b", 32'(disp_b), 32'd3);
        chk("wake_func", 32'(disp_func), 32'(MUL));
        disp_ready = 1'b1;
        step();
        quiet();
        chk("wake_count_after", 32'(count), 32'd0);

        // Issue-time CDB bypass.
        issue(SUB, 3'd3, 1'b0, 3'd0, 16'd1, 1'b1, 3'd6, 16'd0);
        cdb(3'd6, 16'd9);
        step();
        quiet();
        chk("byp_valid", 32'(disp_valid), 32'd1);
        chk("byp_a", 32'(disp_a), 32'd1);
        chk("byp_b", 32'(disp_b), 32'd9);
        disp_ready = 1'b1;
        step();
        quiet();

        // Both operands woken by one broadcast.
        issue(ADD, 3'd7, 1'b1, 3'd3, 16'd0, 1'b1, 3'd3, 16'd0);
        step();
        quiet();
        chk("both_blocked", 32'(disp_valid), 32'd0);
        cdb(3'd3, 16'h0055);
        step();
        quiet();
        chk("both_a", 32'(disp_a), 32'h0055);
        chk("both_b", 32'(disp_b), 32'h0055);
        disp_ready = 1'b1;
        step();
        quiet();

        // Full queue, out-of-order selection, issue+dispatch in one cycle.
        issue(DIV, 3'd5, 1'b1, 3'd7, 16'd0, 1'b0, 3'd0, 16'd2);
        step();
        issue(ADD, 3'd6, 1'b0, 3'd0, 16'd10, 1'b0, 3'd0, 16'd20);
        step();
        issue(SUB, 3'd0, 1'b0, 3'd0, 16'd30, 1'b0, 3'd0, 16'd40);
        step();
        quiet();
        chk("full_count", 32'(count), 32'd3);
        chk("full_iss_ready", 32'(iss_ready), 32'd0);
        chk("full_first_rob", 32'(disp_rob), 32'd6);
        chk("full_first_a", 32'(disp_a), 32'd10);
        disp_ready = 1'b1;
        step();
        quiet();
        chk("ord_count", 32'(count), 32'd2);
        chk("ord_iss_ready", 32'(iss_ready), 32'd1);
        chk("ord_second_rob", 32'(disp_rob), 32'd0);
        issue(ADD, 3'd4, 1'b0, 3'd0, 16'd50, 1'b0, 3'd0, 16'd60);
        disp_ready = 1'b1;
        step();
        quiet();
        chk("iss_disp_count", 32'(count), 32'd2);
        chk("iss_disp_rob", 32'(disp_rob), 32'd4);
        chk("iss_disp_a", 32'(disp_a), 32'd50);
        cdb(3'd7, 16'h0123);
        step();
        quiet();
        chk("older_switch_rob", 32'(disp_rob), 32'd5);
        chk("older_switch_a", 32'(disp_a), 32'h0123);
        chk("older_switch_b", 32'(disp_b), 32'd2);
        disp_ready = 1'b1;
        step();
        quiet();
        chk("drain_rob", 32'(disp_rob), 32'd4);
        chk("drain_count", 32'(count), 32'd1);
        disp_ready = 1'b1;
        step();
        quiet();
        chk("drain_empty", 32'(count), 32'd0);

        // Flush beats issue and dispatch.
        issue(ADD, 3'd1, 1'b0, 3'd0, 16'd1, 1'b0, 3'd0, 16'd1);
        step();
        issue(ADD, 3'd2, 1'b0, 3'd0, 16'd2, 1'b0, 3'd0, 16'd2);
        step();
        issue(ADD, 3'd3, 1'b0, 3'd0, 16'd3, 1'b0, 3'd0, 16'd3);
        step();
        chk("fl_full", 32'(count), 32'd3);
        flush      = 1'b1;
        disp_ready = 1'b1;
        #1;
        chk("fl_disp_valid", 32'(disp_valid), 32'd0);
        step();
        quiet();
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_iss_ready", 32'(iss_ready), 32'd1);
        chk("fl_disp_after", 32'(disp_valid), 32'd0);

        // Flush with room: the concurrent issue must be dropped.
        issue(ADD, 3'd1, 1'b0, 3'd0, 16'd1, 1'b0, 3'd0, 16'd1);
        step();
        issue(ADD, 3'd2, 1'b0, 3'd0, 16'd2, 1'b0, 3'd0, 16'd2);
        flush = 1'b1;
        step();
        quiet();
        chk("fl2_count", 32'(count), 32'd0);

        // Asynchronous reset with two entries held.
        issue(MUL, 3'd1, 1'b1, 3'd5, 16'd0, 1'b0, 3'd0, 16'd1);
        step();
        issue(ADD, 3'd2, 1'b0, 3'd0, 16'd4, 1'b0, 3'd0, 16'd4);
        step();
        quiet();
        chk("ar_pre_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_disp_valid", 32'(disp_valid), 32'd0);
        chk("ar_iss_ready", 32'(iss_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("ar_post_count", 32'(count), 32'd0);
        chk("ar_post_disp", 32'(disp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
